// File: rtl/sysbus_arbiter_if.sv
// Sysbus arbiter port bundle: requester side (req_*/resp_*) plus the shared bus master port (bus_*).
// master = arbiter view, slave = requesters/bus view.
interface sysbus_arbiter_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
);
  localparam int unsigned ADDR_WIDTH = 64;

  logic [1:0]                          req_valid;
  logic [1:0][ADDR_WIDTH-1:0]          req_addr;
  logic [1:0][BUS_TAG_WIDTH-1:0]       req_tag;
  logic [1:0]                          req_ready;
  logic [1:0]                          resp_valid;
  logic [BUS_DATA_WIDTH-1:0]           resp_data;
  logic                                resp_last;
  logic                                tag_err;

  logic                                bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]           bus_req;
  logic [BUS_TAG_WIDTH-1:0]            bus_reqtag;
  logic                                bus_reqack;
  logic                                bus_respcyc;
  logic                                bus_respack;
  logic [BUS_DATA_WIDTH-1:0]           bus_resp;
  logic [BUS_TAG_WIDTH-1:0]            bus_resptag;

  modport master (
    input  req_valid, req_addr, req_tag,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output req_ready, resp_valid, resp_data, resp_last, tag_err,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport slave (
    output req_valid, req_addr, req_tag,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  req_ready, resp_valid, resp_data, resp_last, tag_err,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus master port between fetch (0) and data (1) requesters, one read transaction at a time.
// Define SYSBUS_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module sysbus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8
) (
  input  logic             clk,
  input  logic             reset,
  sysbus_arbiter_if.master sb
);
  localparam int unsigned CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                    state;
  logic                      owner;
  logic [CNT_WIDTH-1:0]      count;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic                      reqcyc_q;
`ifdef SYSBUS_ARB_RR_EN
  logic                      ptr;
`endif

  logic win;
  logic grant;
  logic beat_in;
  logic beat_ok;
  logic beat_bad;
  logic beat_last;

  // Winner selection and beat classification; reset gates everything to zero immediately.
  always_comb begin
`ifdef SYSBUS_ARB_RR_EN
    win = (&sb.req_valid) ? ~ptr : sb.req_valid[1];
`else
    win = sb.req_valid[1];
`endif
    grant     = !reset && (state == IDLE) && (|sb.req_valid);
    beat_in   = !reset && (state == WAIT) && sb.bus_respcyc;
    beat_ok   = beat_in && (sb.bus_resptag == tag_q);
    beat_bad  = beat_in && (sb.bus_resptag != tag_q);
    beat_last = beat_ok && (count == LAST_CNT);
  end

  always_comb begin
    sb.req_ready   = '0;
    sb.resp_valid  = '0;
    sb.resp_data   = '0;
    sb.resp_last   = beat_last;
    sb.tag_err     = beat_bad;
    sb.bus_respack = beat_in;
    if (grant) begin
      sb.req_ready[win] = 1'b1;
    end
    if (beat_ok) begin
      sb.resp_valid[owner] = 1'b1;
      sb.resp_data         = sb.bus_resp;
    end
  end

  assign sb.bus_reqcyc = reqcyc_q;
  assign sb.bus_req    = addr_q;
  assign sb.bus_reqtag = tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      count    <= '0;
      addr_q   <= '0;
      tag_q    <= '0;
      reqcyc_q <= 1'b0;
`ifdef SYSBUS_ARB_RR_EN
      ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= win;
            addr_q   <= BUS_DATA_WIDTH'(sb.req_addr[win]);
            tag_q    <= sb.req_tag[win];
            reqcyc_q <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (sb.bus_reqack) begin
            reqcyc_q <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Mismatched-tag beats are acked but leave the count alone.
          if (beat_last) begin
            count <= '0;
            state <= IDLE;
`ifdef SYSBUS_ARB_RR_EN
            ptr   <= owner;
`endif
          end else if (beat_ok) begin
            count <= count + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed + randomized bench for sysbus_arbiter against a transaction-level reference model.
// Honors SYSBUS_ARB_RR_EN to pick the expected tie-break rule.
module tb_sysbus_arbiter;
  localparam int unsigned DW    = 64;
  localparam int unsigned TW    = 13;
  localparam int unsigned BEATS = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) sb ();

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  int checks   = 0;
  int failures = 0;
  int prio     = 1;  // requester favoured when both ask at once (round-robin build)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule for who wins a grant.
  function automatic int pick(input logic [1:0] v);
`ifdef SYSBUS_ARB_RR_EN
    if (v == 2'b11) return prio;
`endif
    return v[1] ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    sb.req_valid   = '0;
    sb.req_addr    = '0;
    sb.req_tag     = '0;
    sb.bus_reqack  = 1'b0;
    sb.bus_respcyc = 1'b0;
    sb.bus_resp    = '0;
    sb.bus_resptag = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  64'(sb.req_ready),   64'd0);
    chk({tag, "_resp_valid"}, 64'(sb.resp_valid),  64'd0);
    chk({tag, "_resp_data"},  64'(sb.resp_data),   64'd0);
    chk({tag, "_resp_last"},  64'(sb.resp_last),   64'd0);
    chk({tag, "_tag_err"},    64'(sb.tag_err),     64'd0);
    chk({tag, "_reqcyc"},     64'(sb.bus_reqcyc),  64'd0);
    chk({tag, "_bus_req"},    64'(sb.bus_req),     64'd0);
    chk({tag, "_reqtag"},     64'(sb.bus_reqtag),  64'd0);
    chk({tag, "_respack"},    64'(sb.bus_respack), 64'd0);
  endtask

  // One transaction: grant, request phase, beats. bad_at = respcyc beat index carrying a wrong tag
  // (-1 none); abort_at = good-beat count at which reset is pulsed (-1 none).
  task automatic txn(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                     input int ack_dly, input int bad_at, input bit seq, input int abort_at);
    logic [TW-1:0] t0, t1, etag;
    logic [63:0]   eaddr, d;
    logic [1:0]    onehot;
    int            w, good, beat;
    t0 = {2'b11, 11'($urandom)};
    t1 = {2'b11, 11'($urandom)};
    w      = pick(v);
    onehot = (w == 1) ? 2'b10 : 2'b01;
    eaddr  = (w == 1) ? a1 : a0;
    etag   = (w == 1) ? t1 : t0;

    sb.req_valid   = v;
    sb.req_addr[0] = a0;
    sb.req_addr[1] = a1;
    sb.req_tag[0]  = t0;
    sb.req_tag[1]  = t1;
    #1;
    chk("grant", 64'(sb.req_ready), 64'(onehot));
    chk("reqcyc_before", 64'(sb.bus_reqcyc), 64'd0);
    tick();

    for (int i = 0; i <= ack_dly; i++) begin
      sb.bus_reqack  = (i == ack_dly);
      sb.bus_respcyc = 1'($urandom_range(0, 1));
      sb.bus_resptag = etag;
      #1;
      chk("reqcyc", 64'(sb.bus_reqcyc), 64'd1);
      chk("bus_req", 64'(sb.bus_req), eaddr);
      chk("bus_reqtag", 64'(sb.bus_reqtag), 64'(etag));
      chk("no_regrant", 64'(sb.req_ready), 64'd0);
      chk("req_respack", 64'(sb.bus_respack), 64'd0);
      chk("req_resp_valid", 64'(sb.resp_valid), 64'd0);
      tick();
    end
    sb.bus_reqack = 1'b0;

    good = 0;
    beat = 0;
    while (good < int'(BEATS)) begin
      if (good == abort_at) begin
        sb.bus_respcyc = 1'b1;
        sb.bus_resptag = etag;
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        tick();
        reset          = 1'b0;
        sb.bus_respcyc = 1'b0;
        sb.req_valid   = '0;
        prio           = 1;
        #1;
        chk("abort_idle_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        sb.bus_respcyc = 1'b0;
        #1;
        chk("gap_respack", 64'(sb.bus_respack), 64'd0);
        chk("gap_resp_valid", 64'(sb.resp_valid), 64'd0);
        chk("wait_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
        tick();
      end
      d = seq ? 64'(good) : {$urandom, $urandom};
      sb.bus_respcyc = 1'b1;
      sb.bus_resp    = d;
      if (beat == bad_at) begin
        sb.bus_resptag = etag ^ TW'(1);
        #1;
        chk("bad_respack", 64'(sb.bus_respack), 64'd1);
        chk("bad_resp_valid", 64'(sb.resp_valid), 64'd0);
        chk("bad_tag_err", 64'(sb.tag_err), 64'd1);
        chk("bad_resp_last", 64'(sb.resp_last), 64'd0);
      end else begin
        sb.bus_resptag = etag;
        #1;
        chk("respack", 64'(sb.bus_respack), 64'd1);
        chk("resp_valid", 64'(sb.resp_valid), 64'(onehot));
        chk("resp_data", sb.resp_data, d);
        chk("resp_last", 64'(sb.resp_last), 64'(good == int'(BEATS) - 1));
        chk("tag_err", 64'(sb.tag_err), 64'd0);
        good++;
      end
      beat++;
      tick();
    end
    chk("beat_count", 64'(beat), 64'(int'(BEATS) + ((bad_at >= 0) ? 1 : 0)));
    sb.bus_respcyc = 1'b0;
    sb.req_valid   = '0;
    prio           = 1 - w;
    #1;
    chk("done_resp_valid", 64'(sb.resp_valid), 64'd0);
    chk("done_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
    chk("done_req_ready", 64'(sb.req_ready), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    sb.req_valid   = 2'b11;
    sb.bus_respcyc = 1'b1;
    tick();
    chk_all_zero("reset");
    idle_inputs();
    reset = 1'b0;
    tick();

    // Stray response traffic while idle.
    sb.bus_respcyc = 1'b1;
    sb.bus_resptag = '0;
    #1;
    chk("stray_respack", 64'(sb.bus_respack), 64'd0);
    chk("stray_resp_valid", 64'(sb.resp_valid), 64'd0);
    chk("stray_tag_err", 64'(sb.tag_err), 64'd0);
    tick();
    chk("stray_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
    sb.bus_respcyc = 1'b0;

    txn(2'b01, 64'h1000, 64'h2000, 3, -1, 1'b1, -1);

    for (int i = 0; i < 4; i++)
      txn(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 2)), -1, 1'b0, -1);

    txn(2'b10, 64'h0, 64'hdead_beef_0000_0040, 10, -1, 1'b0, -1);
    txn(2'b01, 64'h0000_0000_0000_3fc0, 64'h0, 1, 3, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] v;
      int         bad;
      v   = 2'($urandom_range(1, 3));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      txn(v, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 4)), bad, 1'b0, -1);
    end

    txn(2'b01, 64'h0000_0000_0000_8000, 64'h0, 0, -1, 1'b1, 4);
    txn(2'b11, 64'h0000_0000_0000_9000, 64'h0000_0000_0000_a000, 1, -1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
